i2c_slave_regs: RTL and testbench

I2C target (slave) engine with a 16-byte register bank, answering the master-side bit-shift engine on the same two-wire bus. It decodes START/STOP/repeated START and matches a 7-bit address. It accepts a register pointer followed by write data with auto-increment, and serves reads from the pointer with auto-increment. It is used to emulate the PCF8563 RTC in simulation and on the FPGA loopback build. A local host port lets surrounding logic, such as the time-keeping counter, read and update the registers.

---
 rtl/i2c_slave_regs.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
// I2C target engine with a REG_NUM x 8-bit register bank (PCF8563 emulation).
// Decodes START / STOP / repeated START, matches a 7-bit address, takes a
// register pointer followed by auto-incrementing writes, and serves
// auto-incrementing reads from the pointer. Never stretches SCL.
//
// Ports
//   clk          system clock (>= 16x SCL)
//   rstn         asynchronous active-low reset
//   i2c_sclk     bus clock input
//   i2c_sdat     open-drain data (driven 0 or released)
//   host_addr    host register index
//   host_rdata   combinational read of reg[host_addr]
//   host_we      host write strobe (one clk)
//   host_wdata   host write data
//   bus_wr       one-clk pulse when the bus writes a register
//   bus_wr_addr  index written (valid with bus_wr)
//   bus_wr_data  data written (valid with bus_wr)
//   busy         high while the engine is not IDLE
// ---------------------------------------------------------------------------
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h51,
    parameter int         REG_NUM    = 16,
    localparam int        PW         = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i2c_sclk,
    inout  wire           i2c_sdat,
    input  logic [PW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic          bus_wr,
    output logic [PW-1:0] bus_wr_addr,
    output logic [7:0]    bus_wr_data,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    // Synchronizers: reset to 1 so an idle bus produces no spurious edges.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_sclk};
            sda_sync_q <= {sda_sync_q[0], i2c_sdat};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_evt =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_evt  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [6:0]    shift_q, shift_d;    // 7 bits: the 8th rx bit is taken live from sda_s
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          rw_q, rw_d;
    logic          first_q, first_d;    // next written byte is the pointer
    logic          bus_wr_q, bus_wr_d;
    logic [PW-1:0] bus_wr_addr_q, bus_wr_addr_d;
    logic [7:0]    bus_wr_data_q, bus_wr_data_d;

    logic [7:0] regs_q [REG_NUM];
    logic [7:0] rx_byte, rd_byte;

    assign rx_byte = {shift_q, sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        ptr_d         = ptr_q;
        sda_oe_d      = sda_oe_q;
        rw_d          = rw_q;
        first_d       = first_q;
        bus_wr_d      = 1'b0;
        bus_wr_addr_d = bus_wr_addr_q;
        bus_wr_data_d = bus_wr_data_q;

        if (start_evt) begin
            state_d  = ADDR;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else if (stop_evt) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (shift_q == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = sda_s;
                            first_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                // In the ACK states sda_oe_q doubles as the phase flag:
                // first fall pulls SDA low, second fall ends the ACK slot.
                ADDR_ACK: if (scl_fall) begin
                    cnt_d = 3'd0;
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (rw_q) begin
                        state_d  = RD_BYTE;
                        shift_d  = rd_byte[6:0];
                        sda_oe_d = ~rd_byte[7];
                    end else begin
                        state_d  = WR_BYTE;
                        sda_oe_d = 1'b0;
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = WR_ACK;
                        if (first_q) begin
                            ptr_d   = rx_byte[PW-1:0];
                            first_d = 1'b0;
                        end else begin
                            bus_wr_d      = 1'b1;
                            bus_wr_addr_d = ptr_q;
                            bus_wr_data_d = rx_byte;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = WR_BYTE;
                        cnt_d    = 3'd0;
                    end
                end
                RD_BYTE: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_ACK;
                        cnt_d    = 3'd0;
                    end else begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[5:0], 1'b0};
                        cnt_d    = cnt_q + 3'd1;
                    end
                end
                // cnt_q = 1 marks "master ACKed, load next byte on the fall".
                RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (sda_s) state_d = WAIT_STOP;
                        else       cnt_d   = 3'd1;
                    end else if (scl_fall && cnt_q == 3'd1) begin
                        state_d  = RD_BYTE;
                        cnt_d    = 3'd0;
                        shift_d  = rd_byte[6:0];
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            shift_q       <= 7'd0;
            ptr_q         <= '0;
            sda_oe_q      <= 1'b0;
            rw_q          <= 1'b0;
            first_q       <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_wr_addr_q <= '0;
            bus_wr_data_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            ptr_q         <= ptr_d;
            sda_oe_q      <= sda_oe_d;
            rw_q          <= rw_d;
            first_q       <= first_d;
            bus_wr_q      <= bus_wr_d;
            bus_wr_addr_q <= bus_wr_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
        end
    end

    // Register bank: a bus write to the same index overrides the host write.
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                regs_q[gi] <= 8'd0;
            end else if (bus_wr_d && ptr_q == PW'(gi)) begin
                regs_q[gi] <= rx_byte;
            end else if (host_we && host_addr == PW'(gi)) begin
                regs_q[gi] <= host_wdata;
            end
        end
    end

    assign i2c_sdat    = sda_oe_q ? 1'b0 : 1'bz;
    assign host_rdata  = regs_q[host_addr];
    assign bus_wr      = bus_wr_q;
    assign bus_wr_addr = bus_wr_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regs
// Bit-banged I2C master driving i2c_slave_regs. Table-driven write bursts,
// hand-written read / mismatch / collision / reset sequences, and a
// scoreboard queue of expected bus_wr events checked by a monitor.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regs;

    localparam int Q = 5;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = 8'd0;
    wire  [7:0] host_rdata;
    wire        bus_wr;
    wire  [3:0] bus_wr_addr;
    wire  [7:0] bus_wr_data;
    wire        busy;
    wire        sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regs dut (
        .clk        (clk),
        .rstn       (rstn),
        .i2c_sclk   (scl),
        .i2c_sdat   (sda),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .bus_wr     (bus_wr),
        .bus_wr_addr(bus_wr_addr),
        .bus_wr_data(bus_wr_data),
        .busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] a0;
        logic [3:0] a1;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for bus_wr pulses.
    logic bus_wr_prev = 1'b0;
    always @(negedge clk) begin
        if (rstn && bus_wr) begin
            check("bus_wr_single_clk", {31'd0, bus_wr_prev}, 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bus_wr_unexpected: got addr=%0d data=0x%0h expected no write",
                         bus_wr_addr, bus_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus_wr_addr !== e.a || bus_wr_data !== e.d) begin
                    failures++;
                    $display("FAIL bus_wr: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             bus_wr_addr, bus_wr_data, e.a, e.d);
                end
            end
        end
        bus_wr_prev <= bus_wr;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Optional hook pulses host_we exactly on the clk the DUT commits a bus
    // write for this bit (3 clk after the SCL pin rises).
    task automatic write_bit(input logic b, input logic hook, input logic [3:0] ha,
                             input logic [7:0] hd);
        sda_low = ~b;
        wclk(Q);
        scl = 1'b1;
        wclk(2);
        if (hook) begin
            host_addr  = ha;
            host_wdata = hd;
            host_we    = 1'b1;
        end
        wclk(1);
        host_we = 1'b0;
        wclk(2 * Q - 3);
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_low = 1'b0;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        b = sda;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        sda_low = 1'b1;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        sda_low = 1'b0;
        wclk(Q + 3);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack_bit, input string name,
                              input logic hook, input logic [3:0] ha, input logic [7:0] hd);
        logic ack;
        for (int i = 7; i >= 0; i--) write_bit(b[i], hook && (i == 0), ha, hd);
        read_bit(ack);
        check(name, {31'd0, ack}, {31'd0, exp_ack_bit});
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        write_bit(nack, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic check_reg(input logic [3:0] idx, input logic [7:0] exp);
        host_addr = idx;
        #1;
        check($sformatf("reg%0d", idx), {24'd0, host_rdata}, {24'd0, exp});
    endtask

    task automatic host_write(input logic [3:0] idx, input logic [7:0] d);
        host_addr  = idx;
        host_wdata = d;
        host_we    = 1'b1;
        wclk(1);
        host_we = 1'b0;
        #1;
        check("host_write_visible", {24'd0, host_rdata}, {24'd0, d});
    endtask

    // Full write transaction: address 0xA2, pointer, two data bytes.
    task automatic write_txn(input vec_t v);
        i2c_start();
        write_byte(8'hA2, 1'b0, "ack_addr_wr", 1'b0, 4'd0, 8'd0);
        check("busy_mid_txn", {31'd0, busy}, 32'd1);
        write_byte(v.ptr, 1'b0, "ack_ptr", 1'b0, 4'd0, 8'd0);
        exp_q.push_back('{v.a0, v.d0});
        write_byte(v.d0, 1'b0, "ack_data0", 1'b0, 4'd0, 8'd0);
        exp_q.push_back('{v.a1, v.d1});
        write_byte(v.d1, 1'b0, "ack_data1", 1'b0, 4'd0, 8'd0);
        i2c_stop();
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check_reg(v.a0, v.d0);
        check_reg(v.a1, v.d1);
        $display("txn write ptr=0x%02h data=0x%02h,0x%02h -> reg%0d,reg%0d",
                 v.ptr, v.d0, v.d1, v.a0, v.a1);
    endtask

    initial begin
        logic [7:0] rb;

        vecs[0] = '{8'h0F, 8'hAA, 8'hBB, 4'd15, 4'd0};  // pointer wrap 15 -> 0
        vecs[1] = '{8'h23, 8'h5C, 8'hC5, 4'd3,  4'd4};  // upper pointer bits ignored
        vecs[2] = '{8'h08, 8'h01, 8'h80, 4'd8,  4'd9};
        vecs[3] = '{8'h03, 8'h12, 8'h34, 4'd3,  4'd4};  // burst, leaves ptr = 5

        // Reset state
        wclk(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
        check("rst_bus_wr_addr", {28'd0, bus_wr_addr}, 32'd0);
        check("rst_bus_wr_data", {24'd0, bus_wr_data}, 32'd0);
        check("rst_sda_released", {31'd0, sda}, 32'd1);
        check_reg(4'd3, 8'h00);
        wclk(1);
        rstn = 1'b1;
        wclk(3);

        for (int i = 0; i < 4; i++) write_txn(vecs[i]);

        // Current-address read proves ptr = 5 after the burst
        host_write(4'd5, 8'h59);
        host_write(4'd6, 8'h23);
        host_write(4'd7, 8'h7E);
        i2c_start();
        write_byte(8'hA3, 1'b0, "ack_addr_rd", 1'b0, 4'd0, 8'd0);
        read_byte(rb, 1'b1);
        check("rd_cur_ptr5", {24'd0, rb}, 32'h59);
        i2c_stop();
        $display("txn read current -> 0x%02h", rb);

        // Random read with repeated START, ACK then NACK
        i2c_start();
        write_byte(8'hA2, 1'b0, "ack_addr_wr", 1'b0, 4'd0, 8'd0);
        write_byte(8'h05, 1'b0, "ack_ptr", 1'b0, 4'd0, 8'd0);
        i2c_start();
        write_byte(8'hA3, 1'b0, "ack_addr_rd", 1'b0, 4'd0, 8'd0);
        read_byte(rb, 1'b0);
        check("rd_byte0", {24'd0, rb}, 32'h59);
        read_byte(rb, 1'b1);
        check("rd_byte1", {24'd0, rb}, 32'h23);
        check("sda_released_after_nack", {31'd0, sda}, 32'd1);
        i2c_stop();
        $display("txn random read reg5,reg6 -> 0x59,0x%02h", rb);

        // ptr advanced to 7 by the NACKed byte
        i2c_start();
        write_byte(8'hA3, 1'b0, "ack_addr_rd", 1'b0, 4'd0, 8'd0);
        read_byte(rb, 1'b1);
        check("rd_cur_ptr7", {24'd0, rb}, 32'h7E);
        i2c_stop();
        $display("txn read current -> 0x%02h", rb);

        // Address mismatch: never ACKed, no writes
        i2c_start();
        write_byte(8'hA4, 1'b1, "nack_addr_mismatch", 1'b0, 4'd0, 8'd0);
        write_byte(8'h00, 1'b1, "nack_data_mismatch", 1'b0, 4'd0, 8'd0);
        i2c_stop();
        check_reg(4'd0, 8'hBB);
        check_reg(4'd3, 8'h12);
        check("busy_after_mismatch", {31'd0, busy}, 32'd0);
        $display("txn write to 0xA4 ignored");

        // Host/bus collision: same index bus wins, different index both land
        i2c_start();
        write_byte(8'hA2, 1'b0, "ack_addr_wr", 1'b0, 4'd0, 8'd0);
        write_byte(8'h04, 1'b0, "ack_ptr", 1'b0, 4'd0, 8'd0);
        exp_q.push_back('{4'd4, 8'h55});
        write_byte(8'h55, 1'b0, "ack_coll0", 1'b1, 4'd4, 8'h77);
        exp_q.push_back('{4'd5, 8'h66});
        write_byte(8'h66, 1'b0, "ack_coll1", 1'b1, 4'd9, 8'h99);
        i2c_stop();
        check_reg(4'd4, 8'h55);
        check_reg(4'd5, 8'h66);
        check_reg(4'd9, 8'h99);
        $display("txn collision write reg4=0x55 reg5=0x66 host reg9=0x99");

        // Reset while the slave is driving SDA low
        host_write(4'd0, 8'h11);
        i2c_start();
        write_byte(8'hA2, 1'b0, "ack_addr_wr", 1'b0, 4'd0, 8'd0);
        write_byte(8'h00, 1'b0, "ack_ptr", 1'b0, 4'd0, 8'd0);
        i2c_start();
        write_byte(8'hA3, 1'b0, "ack_addr_rd", 1'b0, 4'd0, 8'd0);
        check("sda_driven_before_reset", {31'd0, sda}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("sda_released_by_reset", {31'd0, sda}, 32'd1);
        check("busy_in_reset", {31'd0, busy}, 32'd0);
        check_reg(4'd0, 8'h00);
        check_reg(4'd4, 8'h00);
        check_reg(4'd9, 8'h00);
        wclk(2);
        rstn = 1'b1;
        wclk(3);
        $display("txn reset mid-read");

        write_txn('{8'h02, 8'h66, 8'h3C, 4'd2, 4'd3});

        wclk(10);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
